// File: rtl/cordic_neuron_sequencer.sv
// Feeds (x,w) pairs through a shared linear-rotation CORDIC as MACs, optionally runs one
// activation pass on the accumulated sum, and returns the neuron output on a valid/ready port.
module cordic_neuron_sequencer #(
  parameter int               WIDTH   = 15,
  parameter int               FRAC    = 10,
  parameter int               LATENCY = 34,
  parameter logic [1:0]       SEL_MAC = 2'b00,
  parameter logic [1:0]       SEL_ACT = 2'b01,
  parameter int               ACT_EN  = 1,
  // 0.5 in the Q.FRAC data format (16'h0200 with the default widths)
  parameter logic [WIDTH:0]   ACT_X0  = (WIDTH+1)'(1) << (FRAC - 1)
) (
  input  logic             clk,
  input  logic             ext_reset,
  input  logic [WIDTH:0]   bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_x,
  input  logic [WIDTH:0]   in_w,
  input  logic             in_last,
  output logic [WIDTH:0]   c_xo,
  output logic [WIDTH:0]   c_yo,
  output logic [WIDTH:0]   c_zo,
  output logic [1:0]       c_sel,
  output logic             c_reset,
  input  logic [WIDTH:0]   c_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, CAPT, ACT_LOAD, ACT_RUN, ACT_CAPT, OUT
  } state_t;

  state_t           state_reg;
  logic [WIDTH:0]   acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_reg;
  logic             first_reg;

  // Operands live directly in the c_xo/c_yo/c_zo registers so they stay stable through RUN/CAPT.
  always_ff @(posedge clk) begin
    if (ext_reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      last_reg  <= 1'b0;
      first_reg <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      c_reset   <= 1'b1;
      c_sel     <= SEL_MAC;
      c_xo      <= '0;
      c_yo      <= '0;
      c_zo      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            last_reg  <= in_last;
            first_reg <= 1'b0;
            in_ready  <= 1'b0;
            c_xo      <= in_x;
            c_zo      <= in_w;
            c_sel     <= SEL_MAC;
            c_reset   <= 1'b1;
            if (first_reg) begin
              acc_reg <= bias;
              c_yo    <= bias;
            end else begin
              c_yo    <= acc_reg;
            end
            state_reg <= LOAD;
          end
        end

        LOAD: begin
          cnt_reg   <= '0;
          c_reset   <= 1'b0;
          state_reg <= RUN;
        end

        RUN: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(LATENCY - 1)) begin
            c_reset   <= 1'b1;
            state_reg <= CAPT;
          end
        end

        CAPT: begin
          acc_reg <= c_z;
          if (!last_reg) begin
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end else if (ACT_EN != 0) begin
            c_xo      <= ACT_X0;
            c_yo      <= '0;
            c_zo      <= c_z;
            c_sel     <= SEL_ACT;
            state_reg <= ACT_LOAD;
          end else begin
            out_data  <= c_z;
            out_valid <= 1'b1;
            state_reg <= OUT;
          end
        end

        ACT_LOAD: begin
          cnt_reg   <= '0;
          c_reset   <= 1'b0;
          state_reg <= ACT_RUN;
        end

        ACT_RUN: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(LATENCY - 1)) begin
            c_reset   <= 1'b1;
            state_reg <= ACT_CAPT;
          end
        end

        ACT_CAPT: begin
          out_data  <= c_z;
          out_valid <= 1'b1;
          state_reg <= OUT;
        end

        OUT: begin
          // A stalled consumer keeps the block here; no new pair can enter.
          if (out_ready) begin
            out_valid <= 1'b0;
            first_reg <= 1'b1;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_neuron_sequencer.sv
// Bench for cordic_neuron_sequencer: two instances (raw sum and activation) each driving a
// behavioural CORDIC model; directed vectors with hand-computed Q5.10 results.
module tb_cordic_neuron_sequencer;

  localparam int         LAT     = 34;
  localparam logic [1:0] SEL_MAC = 2'b00;
  localparam logic [1:0] SEL_ACT = 2'b01;

  logic        clk = 1'b0;
  logic        srst;
  logic [15:0] bias      [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_x      [2];
  logic [15:0] in_w      [2];
  logic        in_last   [2];
  logic [15:0] c_xo      [2];
  logic [15:0] c_yo      [2];
  logic [15:0] c_zo      [2];
  logic [1:0]  c_sel     [2];
  logic        c_reset   [2];
  logic [15:0] c_z       [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int beats0  = 0;

  always #5 clk = ~clk;

  // MAC: yo + xo*zo; activation modelled as a distinct fixed function f(z) = 0.5*z + 0x0011.
  function automatic logic [15:0] cordic_f(logic [1:0] sel, logic [15:0] xo, logic [15:0] yo,
                                           logic [15:0] zo);
    logic signed [31:0] p;
    p = ($signed(xo) * $signed(zo)) >>> 10;
    if (sel == SEL_MAC) return yo + p[15:0];
    if (sel == SEL_ACT) return p[15:0] + 16'h0011;
    return 16'h5A5A;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] cz;
    int          mcnt;

    cordic_neuron_sequencer #(.ACT_EN(gi)) dut (
      .clk       (clk),
      .ext_reset (srst),
      .bias      (bias[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_x      (in_x[gi]),
      .in_w      (in_w[gi]),
      .in_last   (in_last[gi]),
      .c_xo      (c_xo[gi]),
      .c_yo      (c_yo[gi]),
      .c_zo      (c_zo[gi]),
      .c_sel     (c_sel[gi]),
      .c_reset   (c_reset[gi]),
      .c_z       (c_z[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_data  (out_data[gi])
    );

    // Result appears LAT cycles after c_reset falls; junk otherwise so early sampling shows.
    always_ff @(posedge clk) begin
      if (c_reset[gi]) begin
        mcnt <= 0;
        cz   <= 16'h7BAD;
      end else begin
        if (mcnt < LAT) mcnt <= mcnt + 1;
        if (mcnt == LAT - 1) cz <= cordic_f(c_sel[gi], c_xo[gi], c_yo[gi], c_zo[gi]);
      end
    end

    assign c_z[gi] = cz;
  end

  always @(posedge clk) if (in_valid[0] && in_ready[0]) beats0 <= beats0 + 1;

  typedef struct {
    logic [15:0]      b;
    logic [3:0][15:0] x;
    logic [3:0][15:0] w;
    int               n;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl[5];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(string name);
    cmp_cnt++;
    err_cnt++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and return #1 after the edge that accepted it; in_valid is left high.
  task automatic send(int d, logic [15:0] b, logic [15:0] x, logic [15:0] w, logic last);
    int t = 0;
    bias[d] = b; in_x[d] = x; in_w[d] = w; in_last[d] = last; in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[d]) begin
      timeout($sformatf("send%0d", d));
      in_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic get_out(int d, string name, logic [15:0] exp);
    int t = 0;
    @(negedge clk);
    while (!out_valid[d] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[d]) begin
      timeout(name);
      return;
    end
    $display("%s: dut%0d out_data=%h expected=%h", name, d, out_data[d], exp);
    check(name, out_data[d], exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int b_before;

    srst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      bias[d] = '0; in_valid[d] = 1'b0; in_x[d] = '0; in_w[d] = '0;
      in_last[d] = 1'b0; out_ready[d] = 1'b1;
    end
    repeat (3) tick();

    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_in_ready%0d", d),  in_ready[d],  1);
      check($sformatf("rst_out_valid%0d", d), out_valid[d], 0);
      check($sformatf("rst_out_data%0d", d),  out_data[d],  0);
      check($sformatf("rst_c_reset%0d", d),   c_reset[d],   1);
      check($sformatf("rst_c_sel%0d", d),     c_sel[d],     SEL_MAC);
      check($sformatf("rst_c_ops%0d", d),     {c_xo[d] | c_yo[d] | c_zo[d]}, 0);
    end
    srst = 1'b0;
    tick();

    // Single pair 0.5*0.25: operands, c_reset timing, and result latency.
    send(0, 16'h0000, 16'h0200, 16'h0100, 1'b1);
    in_valid[0] = 1'b0;
    check("load_xo", c_xo[0], 16'h0200);
    check("load_yo", c_yo[0], 16'h0000);
    check("load_zo", c_zo[0], 16'h0100);
    check("load_sel", c_sel[0], SEL_MAC);
    check("load_c_reset", c_reset[0], 1);
    tick();
    check("run_c_reset", c_reset[0], 0);
    n = 1;
    while (!out_valid[0] && n < 200) begin
      tick();
      n++;
    end
    $display("single pair: out_valid after %0d edges, out_data=%h", n, out_data[0]);
    check("latency", n, LAT + 2);
    check("single_data", out_data[0], 16'h0080);
    tick();

    // Table vectors, in_valid held high across vector boundaries; non-first beats carry junk bias.
    tbl[0].b = 16'h0000; tbl[0].n = 1; tbl[0].exp = 16'h0080;
    tbl[0].x[0] = 16'h0200; tbl[0].w[0] = 16'h0100;
    tbl[1].b = 16'h0080; tbl[1].n = 3; tbl[1].exp = 16'h0040;
    tbl[1].x[0] = 16'h0200; tbl[1].w[0] = 16'h0200;
    tbl[1].x[1] = 16'hFE00; tbl[1].w[1] = 16'h0100;
    tbl[1].x[2] = 16'h0300; tbl[1].w[2] = 16'hFF00;
    tbl[2].b = 16'h7000; tbl[2].n = 1; tbl[2].exp = 16'hB000;
    tbl[2].x[0] = 16'h1000; tbl[2].w[0] = 16'h1000;
    tbl[3].b = 16'hFC00; tbl[3].n = 3; tbl[3].exp = 16'hFFC0;
    tbl[3].x[0] = 16'h0400; tbl[3].w[0] = 16'h0400;
    tbl[3].x[1] = 16'hFF00; tbl[3].w[1] = 16'hFF00;
    tbl[3].x[2] = 16'h0100; tbl[3].w[2] = 16'hFE00;
    tbl[4].b = 16'h0123; tbl[4].n = 1; tbl[4].exp = 16'h0123;
    tbl[4].x[0] = 16'h0000; tbl[4].w[0] = 16'h7FFF;

    b_before = beats0;
    fork
      begin
        for (int v = 0; v < 5; v++)
          for (int k = 0; k < tbl[v].n; k++)
            send(0, (k == 0) ? tbl[v].b : 16'h3C3C, tbl[v].x[k], tbl[v].w[k], k == tbl[v].n - 1);
        in_valid[0] = 1'b0;
      end
      begin
        for (int v = 0; v < 5; v++) get_out(0, $sformatf("vec%0d", v), tbl[v].exp);
      end
    join
    check("beat_count", beats0 - b_before, 9);

    // Output stall: no beat accepted while out_ready is low, data held.
    out_ready[0] = 1'b0;
    send(0, 16'h0100, 16'h0200, 16'h0400, 1'b1);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 200) begin
      tick();
      n++;
    end
    bias[0] = 16'h0040; in_x[0] = 16'h0100; in_w[0] = 16'h0400; in_last[0] = 1'b1;
    in_valid[0] = 1'b1;
    b_before = beats0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("stall_valid%0d", i), out_valid[0], 1);
      check($sformatf("stall_data%0d", i),  out_data[0],  16'h0300);
      check($sformatf("stall_ready%0d", i), in_ready[0],  0);
    end
    check("stall_beats", beats0 - b_before, 0);
    out_ready[0] = 1'b1;
    send(0, 16'h0040, 16'h0100, 16'h0400, 1'b1);
    in_valid[0] = 1'b0;
    get_out(0, "after_stall", 16'h0140);

    // Abort mid-RUN of pair 2, then a fresh vector must start from its own bias.
    send(0, 16'h0080, 16'h0200, 16'h0200, 1'b0);
    send(0, 16'h3C3C, 16'h0100, 16'h0100, 1'b1);
    in_valid[0] = 1'b0;
    repeat (10) tick();
    check("mid_run_c_reset", c_reset[0], 0);
    srst = 1'b1;
    tick();
    check("abort_in_ready", in_ready[0], 1);
    check("abort_out_valid", out_valid[0], 0);
    check("abort_c_reset", c_reset[0], 1);
    check("abort_out_data", out_data[0], 0);
    srst = 1'b0;
    tick();
    send(0, 16'h0010, 16'h0400, 16'h0100, 1'b1);
    in_valid[0] = 1'b0;
    get_out(0, "after_abort", 16'h0110);

    // Activation pass on the ACT_EN=1 instance.
    send(1, 16'h0080, 16'h0200, 16'h0200, 1'b1);
    in_valid[1] = 1'b0;
    n = 0;
    while (c_sel[1] != SEL_ACT && n < 200) begin
      tick();
      n++;
    end
    if (c_sel[1] != SEL_ACT) timeout("act_sel");
    check("act_xo", c_xo[1], 16'h0200);
    check("act_yo", c_yo[1], 16'h0000);
    check("act_zo", c_zo[1], 16'h0180);
    check("act_c_reset", c_reset[1], 1);
    get_out(1, "act_vec0", 16'h00D1);
    send(1, 16'hFF00, 16'h0400, 16'h0200, 1'b0);
    send(1, 16'h3C3C, 16'hFE00, 16'h0100, 1'b1);
    in_valid[1] = 1'b0;
    get_out(1, "act_vec1", 16'h0051);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
